// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared select encodings and register constants for hazard_ctrl
// Contents: SEL_RF/SEL_ALU/SEL_SPEC operand mux selects, REG_PC, NUM_REGS,
//           src_active() helper (source read that is not the PC register).
package hazard_pkg;

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_SPEC = 2'b11;

  localparam logic [3:0] REG_PC   = 4'd15;
  localparam int         NUM_REGS = 16;

  // r15 reads come from pc_out, so they never create a data hazard.
  function automatic logic src_active(input logic use_f, input logic [3:0] addr);
    return use_f && (addr != REG_PC);
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - pending-load scoreboard with per-source lookup
// Ports: clk, rst (sync, active-high); set_en_i/set_addr_i mark a load in flight;
//        clr_en_i/clr_addr_i retire a load writeback; look_*_i register numbers
//        to query, hit_*_o their pending bits; pending_o full vector.
module load_scoreboard
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en_i,
  input  logic [3:0]          set_addr_i,
  input  logic                clr_en_i,
  input  logic [3:0]          clr_addr_i,
  input  logic [3:0]          look_a_i,
  input  logic [3:0]          look_b_i,
  input  logic [3:0]          look_s_i,
  input  logic [3:0]          look_dst_i,
  input  logic [3:0]          look_ldr_i,
  output logic                hit_a_o,
  output logic                hit_b_o,
  output logic                hit_s_o,
  output logic                hit_dst_o,
  output logic                hit_ldr_o,
  output logic [NUM_REGS-1:0] pending_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;

  // Clear is applied first so a new load to the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // Lookups use the registered state only: a writeback releases its
  // consumers on the following cycle.
  assign hit_a_o   = pend_q[look_a_i];
  assign hit_b_o   = pend_q[look_b_i];
  assign hit_s_o   = pend_q[look_s_i];
  assign hit_dst_o = pend_q[look_dst_i];
  assign hit_ldr_o = pend_q[look_ldr_i];
  assign pending_o = pend_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage hazard, forwarding and stall-watchdog controller
// Optional build macro: HAZARD_FWD_EN (ALU_out forwarding; undefined = stall on ex match).
// Ports: clk, rst (sync, active-high); issue_valid, a/b/s_use, A/B/shift_addr,
//        dst_we/dst, is_ldr/ldr_dst describe the decode instruction; ldr_wb/ldr_wb_addr
//        load writeback; sel_A_in/sel_B_in/sel_shift_in operand mux selects;
//        en_A/en_B/en_S operand enables; stall; stall_err sticky watchdog; pending debug.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                a_use,
  input  logic                b_use,
  input  logic                s_use,
  input  logic [3:0]          A_addr,
  input  logic [3:0]          B_addr,
  input  logic [3:0]          shift_addr,
  input  logic                dst_we,
  input  logic [3:0]          dst,
  input  logic                is_ldr,
  input  logic [3:0]          ldr_dst,
  input  logic                ldr_wb,
  input  logic [3:0]          ldr_wb_addr,
  output logic [1:0]          sel_A_in,
  output logic [1:0]          sel_B_in,
  output logic [1:0]          sel_shift_in,
  output logic                en_A,
  output logic                en_B,
  output logic                en_S,
  output logic                stall,
  output logic                stall_err,
  output logic [NUM_REGS-1:0] pending
);

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_STALL - 1);

  logic             ex_valid_q, ex_valid_d;
  logic [3:0]       ex_dst_q, ex_dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic act_a, act_b, act_s;
  logic hit_a, hit_b, hit_s, hit_dst, hit_ldr;
  logic ex_m_a, ex_m_b, ex_m_s;
  logic ld_hazard, ex_hazard, fire, wd_hit;

  assign fire = issue_valid & ~stall;

  load_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (fire & is_ldr),
    .set_addr_i (ldr_dst),
    .clr_en_i   (ldr_wb),
    .clr_addr_i (ldr_wb_addr),
    .look_a_i   (A_addr),
    .look_b_i   (B_addr),
    .look_s_i   (shift_addr),
    .look_dst_i (dst),
    .look_ldr_i (ldr_dst),
    .hit_a_o    (hit_a),
    .hit_b_o    (hit_b),
    .hit_s_o    (hit_s),
    .hit_dst_o  (hit_dst),
    .hit_ldr_o  (hit_ldr),
    .pending_o  (pending)
  );

  assign act_a = src_active(a_use, A_addr);
  assign act_b = src_active(b_use, B_addr);
  assign act_s = src_active(s_use, shift_addr);

  assign ex_m_a = ex_valid_q & (A_addr == ex_dst_q);
  assign ex_m_b = ex_valid_q & (B_addr == ex_dst_q);
  assign ex_m_s = ex_valid_q & (shift_addr == ex_dst_q);

  assign ld_hazard = (act_a & hit_a) | (act_b & hit_b) | (act_s & hit_s)
                   | (dst_we & hit_dst) | (is_ldr & hit_ldr);

  // Without forwarding an execute-stage match must wait one cycle; the
  // stall itself injects the bubble that clears ex_valid.
  assign ex_hazard = ~FWD & ((act_a & ex_m_a) | (act_b & ex_m_b) | (act_s & ex_m_s));

  assign stall = issue_valid & (ld_hazard | ex_hazard);

  assign en_A = fire;
  assign en_B = fire;
  assign en_S = fire;

  always_comb begin
    sel_A_in = SEL_RF;
    if (a_use && (A_addr == REG_PC)) sel_A_in = SEL_SPEC;
    else if (FWD && ex_m_a)          sel_A_in = SEL_ALU;

    sel_B_in = (FWD && act_b && ex_m_b) ? SEL_ALU : SEL_RF;

    sel_shift_in = SEL_RF;
    if (!s_use)                     sel_shift_in = SEL_SPEC;
    else if (FWD && act_s && ex_m_s) sel_shift_in = SEL_ALU;
  end

  // Watchdog: cnt_q counts earlier consecutive stalled cycles, so the
  // MAX_STALL-th stalled cycle flags immediately and the flag then sticks.
  assign wd_hit    = stall & (cnt_q == CNT_LAST);
  assign stall_err = err_q | wd_hit;

  always_comb begin
    ex_valid_d = fire & dst_we & ~is_ldr;
    ex_dst_d   = fire ? dst : ex_dst_q;
    err_d      = err_q | wd_hit;
    if (!stall)                cnt_d = '0;
    else if (cnt_q == CNT_LAST) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_dst_q   <= 4'd0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_dst_q   <= ex_dst_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int MAXS = 4;

  typedef struct {
    bit       rst, iv, a_use, b_use, s_use, dst_we, is_ldr, ldr_wb;
    bit [3:0] a, b, s, dst, ldr_dst, wb_addr;
  } stim_t;

  typedef struct {
    bit [1:0]  sel_a, sel_b, sel_s;
    bit        en, stall, err;
    bit [15:0] pend;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, issue_valid = 0, a_use = 0, b_use = 0, s_use = 0;
  logic [3:0]  A_addr = 0, B_addr = 0, shift_addr = 0, dst = 0, ldr_dst = 0, ldr_wb_addr = 0;
  logic        dst_we = 0, is_ldr = 0, ldr_wb = 0;
  logic [1:0]  sel_A_in, sel_B_in, sel_shift_in;
  logic        en_A, en_B, en_S, stall, stall_err;
  logic [15:0] pending;

  hazard_ctrl #(.MAX_STALL(MAXS), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .a_use(a_use), .b_use(b_use), .s_use(s_use),
    .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr),
    .dst_we(dst_we), .dst(dst), .is_ldr(is_ldr), .ldr_dst(ldr_dst),
    .ldr_wb(ldr_wb), .ldr_wb_addr(ldr_wb_addr),
    .sel_A_in(sel_A_in), .sel_B_in(sel_B_in), .sel_shift_in(sel_shift_in),
    .en_A(en_A), .en_B(en_B), .en_S(en_S),
    .stall(stall), .stall_err(stall_err), .pending(pending)
  );

  // Reference model state: which registers await load data, what execute
  // holds, and how many stalls have happened back to back.
  bit       m_pend [16];
  bit       m_exv;
  bit [3:0] m_exd;
  int       m_run;
  bit       m_err;
  stim_t    cur;
  bit       cur_stall, cur_fire;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic bit busy(bit use_f, bit [3:0] r);
    return use_f && r != 4'd15 && m_pend[r];
  endfunction

  function automatic bit exhit(bit use_f, bit [3:0] r);
    return use_f && r != 4'd15 && m_exv && r == m_exd;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic bit [3:0] raddr();
    if ($urandom_range(0, 7) == 0) return 4'd15;
    return 4'($urandom_range(0, 4));
  endfunction

  function automatic stim_t rand_stim(bit allow_wb);
    stim_t s;
    s.rst     = ($urandom_range(0, 199) == 0);
    s.iv      = ($urandom_range(0, 3) != 0);
    s.a_use   = 1'($urandom_range(0, 1));
    s.b_use   = 1'($urandom_range(0, 1));
    s.s_use   = 1'($urandom_range(0, 1));
    s.a       = raddr();
    s.b       = raddr();
    s.s       = raddr();
    s.dst_we  = 1'($urandom_range(0, 1));
    s.dst     = raddr();
    s.is_ldr  = ($urandom_range(0, 3) == 0);
    s.ldr_dst = raddr();
    s.ldr_wb  = allow_wb && ($urandom_range(0, 2) == 0);
    s.wb_addr = raddr();
    return s;
  endfunction

  // Retire the cycle that just ended into the model.
  task automatic commit();
    if (cur.rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_exv = 0; m_exd = 0; m_run = 0; m_err = 0;
    end else begin
      m_exv = cur_fire && cur.dst_we && !cur.is_ldr;
      if (cur_fire) m_exd = cur.dst;
      if (cur.ldr_wb) m_pend[cur.wb_addr] = 1'b0;
      if (cur_fire && cur.is_ldr) m_pend[cur.ldr_dst] = 1'b1;
      if (cur_stall) begin
        if (m_run + 1 >= MAXS) m_err = 1'b1;
        m_run = m_run + 1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic cycle(input stim_t s);
    exp_t e;
    bit   st;
    @(posedge clk);
    #1;
    commit();
    cur = s;
    rst = s.rst; issue_valid = s.iv; a_use = s.a_use; b_use = s.b_use; s_use = s.s_use;
    A_addr = s.a; B_addr = s.b; shift_addr = s.s; dst_we = s.dst_we; dst = s.dst;
    is_ldr = s.is_ldr; ldr_dst = s.ldr_dst; ldr_wb = s.ldr_wb; ldr_wb_addr = s.wb_addr;

    st = s.iv && (busy(s.a_use, s.a) || busy(s.b_use, s.b) || busy(s.s_use, s.s)
                  || (s.dst_we && m_pend[s.dst]) || (s.is_ldr && m_pend[s.ldr_dst])
                  || (!FWD && (exhit(s.a_use, s.a) || exhit(s.b_use, s.b) || exhit(s.s_use, s.s))));
    cur_stall = st;
    cur_fire  = s.iv && !st;

    if (s.a_use && s.a == 4'd15)          e.sel_a = 2'b11;
    else if (FWD && m_exv && s.a == m_exd) e.sel_a = 2'b01;
    else                                   e.sel_a = 2'b00;
    e.sel_b = (FWD && exhit(s.b_use, s.b)) ? 2'b01 : 2'b00;
    if (!s.s_use)                     e.sel_s = 2'b11;
    else if (FWD && exhit(1'b1, s.s)) e.sel_s = 2'b01;
    else                              e.sel_s = 2'b00;
    e.en    = cur_fire;
    e.stall = st;
    e.err   = m_err || (st && m_run + 1 >= MAXS);
    for (int i = 0; i < 16; i++) e.pend[i] = m_pend[i];
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sel_A_in", int'(sel_A_in), int'(e.sel_a));
        chk("sel_B_in", int'(sel_B_in), int'(e.sel_b));
        chk("sel_shift_in", int'(sel_shift_in), int'(e.sel_s));
        chk("en_A", int'(en_A), int'(e.en));
        chk("en_B", int'(en_B), int'(e.en));
        chk("en_S", int'(en_S), int'(e.en));
        chk("stall", int'(stall), int'(e.stall));
        chk("stall_err", int'(stall_err), int'(e.err));
        chk("pending", int'(pending), int'(e.pend));
      end
    end
  end

  initial begin : driver
    stim_t s;
    cur = nop();
    cur.rst = 1'b1;
    cur_stall = 0;
    cur_fire = 0;
    s = nop(); s.rst = 1; cycle(s); cycle(s);

    // ALU result consumed by the next instruction
    s = nop(); s.iv = 1; s.dst_we = 1; s.dst = 4'd1; cycle(s);
    s = nop(); s.iv = 1; s.a_use = 1; s.a = 4'd1; s.s_use = 1; s.s = 4'd2; cycle(s); cycle(s);

    // load r3, dependent read waits until the cycle after writeback
    s = nop(); s.iv = 1; s.is_ldr = 1; s.ldr_dst = 4'd3; cycle(s);
    s = nop(); s.iv = 1; s.b_use = 1; s.b = 4'd3; cycle(s); cycle(s);
    s.ldr_wb = 1; s.wb_addr = 4'd3; cycle(s);
    s.ldr_wb = 0; cycle(s);

    // PC reads and zero shift
    s = nop(); s.iv = 1; s.dst_we = 1; s.dst = 4'd15; cycle(s);
    s = nop(); s.iv = 1; s.a_use = 1; s.a = 4'd15; s.b_use = 1; s.b = 4'd15; cycle(s);

    // WAW against an outstanding load, then writeback racing a new load
    s = nop(); s.iv = 1; s.is_ldr = 1; s.ldr_dst = 4'd5; cycle(s);
    s = nop(); s.iv = 1; s.dst_we = 1; s.dst = 4'd5; cycle(s);
    s = nop(); s.ldr_wb = 1; s.wb_addr = 4'd5; cycle(s);
    s = nop(); s.iv = 1; s.is_ldr = 1; s.ldr_dst = 4'd5; s.ldr_wb = 1; s.wb_addr = 4'd5; cycle(s);
    s = nop(); cycle(s);

    // watchdog: long stall, error sticks until reset
    s = nop(); s.rst = 1; cycle(s);
    s = nop(); s.iv = 1; s.is_ldr = 1; s.ldr_dst = 4'd7; cycle(s);
    s = nop(); s.iv = 1; s.b_use = 1; s.b = 4'd7;
    for (int i = 0; i < 6; i++) cycle(s);
    s.ldr_wb = 1; s.wb_addr = 4'd7; cycle(s);
    s = nop(); cycle(s); cycle(s);
    s.rst = 1; cycle(s);
    s = nop(); cycle(s);

    // reset in the middle of a stall
    s = nop(); s.iv = 1; s.is_ldr = 1; s.ldr_dst = 4'd2; cycle(s);
    s = nop(); s.iv = 1; s.a_use = 1; s.a = 4'd2; cycle(s);
    s.rst = 1; cycle(s);
    s.rst = 0; cycle(s);

    // randomized traffic, with a stretch of starved writebacks
    for (int i = 0; i < 1200; i++) cycle(rand_stim(1'b1));
    for (int i = 0; i < 200; i++) cycle(rand_stim(1'b0));
    for (int i = 0; i < 600; i++) cycle(rand_stim(1'b1));

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Decode-stage hazard and forwarding controller for the pipelined datapath. It drives the A/B/shift forwarding selects and the operand-register enables (en_A/en_B/en_S). It tracks the destination of the instruction now in execute for ALU_out forwarding, and keeps a 16-entry pending-load scoreboard for LDR results that arrive later on the w_en_ldr port. It raises stall for RAW and WAW hazards it cannot forward, and a watchdog flags stalls that never resolve.

Parameters:
MAX_STALL, 64, consecutive stall cycles before stall_err sets (range 2..255)
CNT_W, 8, width of the stall watchdog counter (must hold MAX_STALL)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
issue_valid  in  1  decode holds a valid instruction
a_use, b_use, s_use  in  1 each  instruction reads A_addr / B_addr / shift_addr
A_addr, B_addr, shift_addr  in  4 each  source register numbers
dst_we  in  1  instruction writes dst via ALU path (w_addr1/w_en1)
dst  in  4  ALU destination register
is_ldr  in  1  instruction is a load; ldr_dst receives memory data later
ldr_dst  in  4  load destination register
ldr_wb  in  1  load writeback this cycle (mirrors w_en_ldr)
ldr_wb_addr  in  4  load writeback register (mirrors w_addr_ldr)
sel_A_in, sel_B_in, sel_shift_in  out  2 each  forwarding mux selects
en_A, en_B, en_S  out  1 each  operand register enables
stall  out  1  hold fetch/decode this cycle
stall_err  out  1  sticky watchdog error
pending  out  16  scoreboard contents (debug)

Behaviour:
- Reset clears ex_valid, ex_dst=0, pending=0, stall counter=0 and stall_err=0. All outputs settle to their combinational values from the reset state: sels 00, or 11 per the rules below.
- Issue is defined as fire = issue_valid & !stall. en_A = en_B = en_S = fire.
- Each clock edge: ex_valid <= fire & dst_we & !is_ldr, and ex_dst <= dst when fire. A non-firing cycle inserts a bubble (ex_valid=0).
- Scoreboard: on fire & is_ldr, set pending[ldr_dst]. On ldr_wb, clear pending[ldr_wb_addr]. If both target the same register in one cycle, the set wins.
- A source is active if its use flag is set and it is not r15.
- Stall is asserted when issue_valid and any of the following holds:
  - an active source has pending[src]=1 (load RAW);
  - dst_we and pending[dst]=1 (WAW vs outstanding load);
  - is_ldr and pending[ldr_dst]=1.
- Stall is purely combinational from the current inputs and state, with no extra latency.
- sel_A_in:
  - 11 (pc_out) if a_use and A_addr=15;
  - otherwise 01 (ALU_out) if ex_valid and A_addr=ex_dst;
  - otherwise 00.
- sel_B_in: 01 if b_use, B_addr≠15, ex_valid and B_addr=ex_dst; otherwise 00.
- sel_shift_in:
  - 11 (zero) if !s_use;
  - otherwise 01 on an ex match (same rule as B);
  - otherwise 00.
- Watchdog:
  - counter increments each cycle stall=1 and clears on any cycle stall=0;
  - when counter reaches MAX_STALL-1 while stalled, stall_err sets;
  - stall_err stays set until rst;
  - the counter saturates.
- Reset mid-stall drops stall the following cycle and discards all pending loads. The memory side must also be reset.

Optional Feature:
HAZARD_FWD_EN.
- Defined: ALU_out forwarding as above.
- Undefined:
  - sel A/B/shift never take 01;
  - an active source equal to ex_dst while ex_valid adds a stall condition;
  - ex_valid is then 0 on the cycle after that stall, so the stall lasts exactly 1 cycle.

Decomposition:
- Package hazard_pkg:
  - SEL_RF=2'b00, SEL_ALU=2'b01, SEL_SPEC=2'b11;
  - REG_PC=4'd15;
  - NUM_REGS=16.
- Sub-module load_scoreboard holds the pending vector, its set/clear logic and a per-source lookup. The top level holds ex tracking, select logic and the watchdog.

Test Plan:
1. ADD r1 (dst_we, dst=1) issues, next cycle issue with A_addr=1, a_use -> sel_A_in=01, stall=0, en_A=1. Without HAZARD_FWD_EN -> stall=1 for 1 cycle, then sel_A_in=00.
2. LDR r3 issues; next instr B_addr=3 -> stall=1, pending[3]=1 until ldr_wb, ldr_wb_addr=3. The cycle after that writeback -> stall=0, sel_B_in=00.
3. A_addr=15, a_use -> sel_A_in=11. B_addr=15, ex_dst=15, ex_valid -> sel_B_in=00. s_use=0 -> sel_shift_in=11.
4. pending[5]=1, dst_we with dst=5 -> stall. Same cycle as ldr_wb for r5 plus a new LDR r5 firing -> pending[5] stays 1.
5. MAX_STALL=4, hold a pending source with no ldr_wb -> stall_err=1 on the 4th stalled cycle and stays 1 after the stall clears. Assert rst -> stall_err=0, pending=0.
6. rst asserted during stall -> next cycle stall=0, pending=0, ex_valid=0, en_A=issue_valid.
